board_pkt_rx: RTL

- Oversampling serial receiver for board-state packets sent by the team's packet transmitter. The packets are 208 bits (162 board bits plus header/pad), sent at 9600 baud on the 65 MHz system clock.
- Sits between an inter-board PMOD pin (jb[0]) and game_fsm.
- Delivers a complete, framing-checked packet on a parallel bus with a one-cycle ready strobe.

---
 rtl/board_pkt_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/board_pkt_rx.sv
// board_pkt_rx: oversampling serial receiver for inter-board board-state packets.
// A frame is one low start bit, PKT_LEN data bits sent LSB first, and one high
// stop bit. Each bit lasts SAMP_PER_BIT*CLK_PER_SAMP clocks. The receiver only
// accepts a start bit after WAITING_COUNT clocks of continuous idle-high line.
// It hands over whole packets only; a packet is never partially written to
// data_out.
//
// Ports:
//   clk_in     system clock
//   rst_in     asynchronous active-high reset
//   rx         asynchronous serial line, idles high
//   data_out   last good packet; bit 0 is the first data bit received
//   ready      one-cycle pulse when data_out is updated
//   frame_err  one-cycle pulse when a stop bit samples low
//   busy       high from start-bit acceptance until the frame ends
module board_pkt_rx #(
  parameter int CLK_PER_SAMP  = 423,
  parameter int SAMP_PER_BIT  = 16,
  parameter int PKT_LEN       = 208,
  parameter int WAITING_COUNT = 130_000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rx,
  output logic [PKT_LEN-1:0] data_out,
  output logic               ready,
  output logic               frame_err,
  output logic               busy
);

  localparam int PW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam int TW = $clog2(SAMP_PER_BIT);
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int IW = $clog2(WAITING_COUNT + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SAMP - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(SAMP_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMP_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(PKT_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(WAITING_COUNT);

  typedef enum logic [2:0] {IDLE_WAIT, ARMED, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic               s1, rs;
  logic [PW-1:0]      presc;
  logic [TW-1:0]      tcnt;
  logic [BW-1:0]      bit_idx;
  logic [IW-1:0]      idle_cnt;
  logic [PKT_LEN-1:0] shift;
  logic               tick;

  // Control strobes decoded by the FSM for the datapath
  logic start_det, glitch, mid_ok, samp_bit, stop_samp;

  assign tick = (presc == PRESC_MAX);

  // Two-flop synchronizer; resets to the idle level so reset never looks
  // like a start edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1 <= 1'b1;
      rs <= 1'b1;
    end else begin
      s1 <= rx;
      rs <= s1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE_WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    glitch    = 1'b0;
    mid_ok    = 1'b0;
    samp_bit  = 1'b0;
    stop_samp = 1'b0;
    case (state)
      IDLE_WAIT: if (idle_cnt == IDLE_MAX) state_nxt = ARMED;
      ARMED: if (!rs) begin
        start_det = 1'b1;
        state_nxt = START;
      end
      // Mid start bit: a high line here means the falling edge was noise.
      START: if (tick && tcnt == TICK_HALF) begin
        if (rs) begin
          glitch    = 1'b1;
          state_nxt = IDLE_WAIT;
        end else begin
          mid_ok    = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: if (tick && tcnt == TICK_LAST) begin
        samp_bit = 1'b1;
        if (bit_idx == BIT_LAST) state_nxt = STOP;
      end
      STOP: if (tick && tcnt == TICK_LAST) begin
        stop_samp = 1'b1;
        state_nxt = IDLE_WAIT;
      end
      default: state_nxt = IDLE_WAIT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc     <= '0;
      tcnt      <= '0;
      bit_idx   <= '0;
      idle_cnt  <= '0;
      shift     <= '0;
      data_out  <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Prescaler restarts on the start edge so every later sample lands
      // at a fixed offset from that edge.
      if (start_det || tick) presc <= '0;
      else                   presc <= presc + 1'b1;

      if (start_det || mid_ok) tcnt <= '0;
      else if (tick)           tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + 1'b1;

      if (mid_ok)                               bit_idx <= '0;
      else if (samp_bit && bit_idx != BIT_LAST) bit_idx <= bit_idx + 1'b1;

      if (samp_bit) shift[bit_idx] <= rs;

      // Idle run length only counts while waiting; every other state leaves
      // it at zero, so each return to IDLE_WAIT starts a fresh wait.
      if (state == IDLE_WAIT) begin
        if (!rs)                  idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      if (start_det)             busy <= 1'b1;
      else if (glitch || stop_samp) busy <= 1'b0;

      ready     <= stop_samp && rs;
      frame_err <= stop_samp && !rs;
      if (stop_samp && rs) data_out <= shift;
    end
  end

endmodule
